// File: rtl/rv_wb_stage_pipe.sv
// Registered write-back stage: valid/ready intake from MEM, NSRC-way result select,
// stall on late load data, load formatting/alignment checks, regfile/forwarding drive
// and a retire counter.
module rv_wb_stage_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NSRC  = 3,
  parameter int unsigned SRC_W = $clog2(NSRC),
  parameter int unsigned CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      pc_in,
  input  logic [31:0]          iw_in,
  input  logic [XLEN-1:0]      alu_in,
  input  logic [NSRC*XLEN-1:0] src_rdata,
  input  logic [NSRC-1:0]      src_rvalid,
  input  logic [4:0]           wb_reg_in,
  input  logic                 wb_enable_in,
  input  logic [SRC_W-1:0]     wb_src_in,
  output logic                 regif_wb_enable,
  output logic [4:0]           regif_wb_reg,
  output logic [XLEN-1:0]      regif_wb_data,
  output logic                 df_wb_enable,
  output logic [4:0]           df_wb_reg,
  output logic [XLEN-1:0]      df_wb_data,
  output logic                 wb_from_mem_out,
  output logic                 wb_stall_out,
  output logic                 load_misalign_err,
  output logic [XLEN-1:0]      retire_pc,
  output logic [CNT_W-1:0]     retire_count
);

  localparam int unsigned OFF_W = $clog2(XLEN / 8);

  typedef enum logic {StIdle, StWait} state_e;

  state_e state_q, state_d;

  // Holding register for the accepted instruction
  logic [XLEN-1:0]  pc_q, alu_q;
  logic [31:0]      iw_q;
  logic [4:0]       reg_q;
  logic             wen_q;
  logic [SRC_W-1:0] src_q;

  // Registered commit outputs
  logic             wb_en_q, from_mem_q, err_q;
  logic [4:0]       wb_reg_q;
  logic [XLEN-1:0]  wb_data_q, retire_pc_q;
  logic [CNT_W-1:0] retire_cnt_q;

  logic             accept, commit, sel_valid, is_load, ld_err, mis_err, err;
  logic [XLEN-1:0]  cur_pc, cur_alu, sel_data, fmt_data, sh_b, sh_h, sh_w;
  logic [31:0]      cur_iw;
  logic [4:0]       cur_reg;
  logic             cur_wen;
  logic [SRC_W-1:0] in_src, cur_src;
  logic [OFF_W-1:0] off, off_h, off_w;
  logic [2:0]       funct3;

  assign in_ready     = (state_q == StIdle);
  assign wb_stall_out = (state_q == StWait);
  assign accept       = in_valid & in_ready;

  // Out-of-range selects fall back to the ALU
  assign in_src = (int'(wb_src_in) < int'(NSRC)) ? wb_src_in : '0;

  // In IDLE the live inputs are committed directly; in WAIT the held copy is used
  always_comb begin
    if (state_q == StIdle) begin
      cur_pc  = pc_in;
      cur_iw  = iw_in;
      cur_alu = alu_in;
      cur_reg = wb_reg_in;
      cur_wen = wb_enable_in;
      cur_src = in_src;
    end else begin
      cur_pc  = pc_q;
      cur_iw  = iw_q;
      cur_alu = alu_q;
      cur_reg = reg_q;
      cur_wen = wen_q;
      cur_src = src_q;
    end
  end

  // Source mux; the ALU result is always valid
  always_comb begin
    sel_data  = cur_alu;
    sel_valid = 1'b1;
    for (int k = 1; k < int'(NSRC); k++) begin
      if (cur_src == SRC_W'(k)) begin
        sel_data  = src_rdata[k*XLEN +: XLEN];
        sel_valid = src_rvalid[k];
      end
    end
  end

  assign commit = (state_q == StIdle) ? (accept & sel_valid) : sel_valid;

  // Next-state: park in WAIT until the selected source delivers
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept && !sel_valid) state_d = StWait;
      StWait: if (sel_valid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Load formatting and alignment checks
  always_comb begin
    is_load  = (cur_iw[6:0] == 7'b0000011);
    funct3   = cur_iw[14:12];
    off      = cur_alu[OFF_W-1:0];
    off_h    = off & ~OFF_W'(1);
    off_w    = off & ~OFF_W'(3);
    sh_b     = sel_data >> {off, 3'b000};
    sh_h     = sel_data >> {off_h, 3'b000};
    sh_w     = sel_data >> {off_w, 3'b000};
    fmt_data = sel_data;
    ld_err   = 1'b0;
    mis_err  = 1'b0;
    if (is_load) begin
      case (funct3)
        3'b000: fmt_data = XLEN'($signed(sh_b[7:0]));
        3'b100: fmt_data = XLEN'(sh_b[7:0]);
        3'b001: begin
          fmt_data = XLEN'($signed(sh_h[15:0]));
          mis_err  = off[0];
        end
        3'b101: begin
          fmt_data = XLEN'(sh_h[15:0]);
          mis_err  = off[0];
        end
        3'b010: begin
          fmt_data = XLEN'($signed(sh_w[31:0]));
          mis_err  = (off[1:0] != 2'b00);
        end
        3'b110: begin
          if (XLEN == 64) begin
            fmt_data = XLEN'(sh_w[31:0]);
            mis_err  = (off[1:0] != 2'b00);
          end else begin
            fmt_data = '0;
            ld_err   = 1'b1;
          end
        end
        3'b011: begin
          if (XLEN == 64) begin
            fmt_data = sel_data;
            mis_err  = (off != '0);
          end else begin
            fmt_data = '0;
            ld_err   = 1'b1;
          end
        end
        default: begin
          fmt_data = '0;
          ld_err   = 1'b1;
        end
      endcase
    end
    err = ld_err | mis_err;
  end

  // State, holding register and commit outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      pc_q         <= '0;
      iw_q         <= '0;
      alu_q        <= '0;
      reg_q        <= '0;
      wen_q        <= 1'b0;
      src_q        <= '0;
      wb_en_q      <= 1'b0;
      from_mem_q   <= 1'b0;
      err_q        <= 1'b0;
      wb_reg_q     <= '0;
      wb_data_q    <= '0;
      retire_pc_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pc_q  <= pc_in;
        iw_q  <= iw_in;
        alu_q <= alu_in;
        reg_q <= wb_reg_in;
        wen_q <= wb_enable_in;
        src_q <= in_src;
      end
      wb_en_q    <= commit & cur_wen & (cur_reg != 5'd0) & ~err;
      from_mem_q <= commit & (cur_src != '0);
      err_q      <= commit & err;
      if (commit) begin
        wb_reg_q    <= cur_reg;
        wb_data_q   <= fmt_data;
        retire_pc_q <= cur_pc;
        if (!err) retire_cnt_q <= retire_cnt_q + CNT_W'(1);
      end
    end
  end

  assign regif_wb_enable   = wb_en_q;
  assign regif_wb_reg      = wb_reg_q;
  assign regif_wb_data     = wb_data_q;
  assign df_wb_enable      = wb_en_q;
  assign df_wb_reg         = wb_reg_q;
  assign df_wb_data        = wb_data_q;
  assign wb_from_mem_out   = from_mem_q;
  assign load_misalign_err = err_q;
  assign retire_pc         = retire_pc_q;
  assign retire_count      = retire_cnt_q;

  // Slice 0 / bit 0 are architecturally unused; other iw fields are not decoded here
  logic unused_bits;
  assign unused_bits = ^{src_rdata[XLEN-1:0], src_rvalid[0], cur_iw[31:15], cur_iw[11:7]};

endmodule
